ysyx_2022040010_icache_refill: RTL and testbench

Refill engine for the two-way instruction cache. On a miss it issues an AXI4 read burst, assembles the returned beats into a 128-bit line, and writes that line into the icache data/tag arrays. It drives `refresh`, `cacheline_new` and the victim way into the data array. Uncacheable fetches run as a single 32-bit AXI read, and the instruction goes straight back to the fetch stage.

---
 rtl/ysyx_2022040010_icache_refill_pkg.sv | 36 +++
 rtl/ysyx_2022040010_icache_refill.sv | 227 ++++++++++++++++++++++
 tb/tb_ysyx_2022040010_icache_refill.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_2022040010_icache_refill_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_2022040010_icache_refill_pkg
// Description : Shared constants for the icache refill engine: AXI burst,
//               size and response codes, cache geometry and the refill FSM
//               state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package ysyx_2022040010_icache_refill_pkg;

  // Cache geometry (128-bit lines, 64 sets per way)
  localparam int c_offset_width = 4;
  localparam int c_index_width  = 6;

  // AXI4 encodings
  localparam logic [1:0] c_burst_incr = 2'b01;
  localparam logic [1:0] c_resp_okay  = 2'b00;
  localparam logic [2:0] c_size_4b    = 3'd2;
  localparam logic [2:0] c_size_8b    = 3'd3;

  // Refill FSM encoding
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_AR     = 3'd1,
    S_R      = 3'd2,
    S_REFILL = 3'd3,
    S_DONE   = 3'd4
  } refill_state_e;

  // Any response other than OKAY marks the whole transaction as failed.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != c_resp_okay;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_2022040010_icache_refill.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_2022040010_icache_refill
// Description : Instruction-cache refill engine. On a miss it issues an AXI4
//               INCR read burst, assembles the beats into one cache line and
//               strobes the line into the data/tag arrays. Uncacheable
//               fetches run as a single 32-bit read whose instruction is
//               returned directly.
// Revision    : 1.0 - initial release
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   miss_req/addr/cache      miss request (level, held until miss_done)
//   lru_in                   victim way from the tag array
//   refresh                  one-cycle array write strobe
//   cacheline_new            assembled line
//   refill_way/refill_index  latched victim way and set index
//   uncached_inst            instruction from an uncached fetch
//   miss_done, bus_err       completion pulse and its failure qualifier
//   ar*, r*                  AXI4 read address / read data channels
// ============================================================================
module ysyx_2022040010_icache_refill
  import ysyx_2022040010_icache_refill_pkg::*;
#(
  parameter int         ADDR_W     = 64,
  parameter int         AXI_DATA_W = 64,
  parameter int         LINE_W     = 128,
  parameter logic [3:0] AXI_ID     = 4'd0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      miss_req,
  input  logic [ADDR_W-1:0]         miss_addr,
  input  logic                      cache,
  input  logic                      lru_in,
  output logic                      refresh,
  output logic [LINE_W-1:0]         cacheline_new,
  output logic                      refill_way,
  output logic [c_index_width-1:0]  refill_index,
  output logic [31:0]               uncached_inst,
  output logic                      miss_done,
  output logic                      bus_err,
  output logic                      arvalid,
  input  logic                      arready,
  output logic [ADDR_W-1:0]         araddr,
  output logic [7:0]                arlen,
  output logic [2:0]                arsize,
  output logic [1:0]                arburst,
  output logic [3:0]                arid,
  input  logic                      rvalid,
  output logic                      rready,
  input  logic [AXI_DATA_W-1:0]     rdata,
  input  logic [1:0]                rresp,
  input  logic                      rlast,
  input  logic [3:0]                rid
);

  localparam int         c_beats      = LINE_W / AXI_DATA_W;
  localparam int         c_beat_w     = (c_beats > 1) ? $clog2(c_beats) : 1;
  localparam logic [7:0] c_arlen_line = 8'(c_beats - 1);

  refill_state_e r_state;
  refill_state_e w_next;

  logic [c_beat_w-1:0]      r_beat;
  logic                     r_err;
  logic                     r_cache;
  logic                     r_addr2;
  logic [LINE_W-1:0]        r_line;
  logic [31:0]              r_inst;
  logic                     r_way;
  logic [c_index_width-1:0] r_index;
  logic [ADDR_W-1:0]        r_araddr;
  logic [7:0]               r_arlen;
  logic [2:0]               r_arsize;
  logic [1:0]               r_arburst;
  logic                     r_arvalid;
  logic                     r_rready;
  logic                     r_refresh;
  logic                     r_miss_done;
  logic                     r_bus_err;

  logic w_beat_acc;
  logic w_beat_err;
  logic w_err_next;
  logic w_unused;

  // rready is high for exactly the cycles spent in R, so a beat is accepted
  // whenever R sees rvalid.
  assign w_beat_acc = (r_state == S_R) && rvalid;

  // A beat is bad on a non-OKAY response, or when rlast arrives on a beat
  // whose index does not match the requested burst length.
  assign w_beat_err = resp_is_err(rresp) ||
                      (rlast && ({{(8 - c_beat_w){1'b0}}, r_beat} != r_arlen));

  assign w_err_next = r_err | (w_beat_acc & w_beat_err);

  // Address bits below the 32-bit word and the returned ID carry no meaning.
  assign w_unused = ^{miss_addr[1:0], rid};

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (miss_req) begin
          w_next = S_AR;
        end
      end
      S_AR: begin
        if (arready) begin
          w_next = S_R;
        end
      end
      S_R: begin
        if (w_beat_acc && rlast) begin
          // Only a clean cached burst may touch the arrays.
          w_next = (r_cache && !w_err_next) ? S_REFILL : S_DONE;
        end
      end
      S_REFILL: w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath and registered outputs. Handshake/strobe outputs are decoded
  // from the next state so they are flops aligned with the state they belong
  // to.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_beat      <= '0;
      r_err       <= 1'b0;
      r_cache     <= 1'b0;
      r_addr2     <= 1'b0;
      r_line      <= '0;
      r_inst      <= '0;
      r_way       <= 1'b0;
      r_index     <= '0;
      r_araddr    <= '0;
      r_arlen     <= '0;
      r_arsize    <= '0;
      r_arburst   <= '0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_refresh   <= 1'b0;
      r_miss_done <= 1'b0;
      r_bus_err   <= 1'b0;
    end else begin
      r_arvalid   <= (w_next == S_AR);
      r_rready    <= (w_next == S_R);
      r_refresh   <= (w_next == S_REFILL);
      r_miss_done <= (w_next == S_DONE);
      r_bus_err   <= (w_next == S_DONE) && w_err_next;

      case (r_state)
        S_IDLE: begin
          if (miss_req) begin
            r_cache   <= cache;
            r_addr2   <= miss_addr[2];
            r_way     <= lru_in;
            r_index   <= miss_addr[c_offset_width +: c_index_width];
            r_beat    <= '0;
            r_err     <= 1'b0;
            r_arburst <= c_burst_incr;
            if (cache) begin
              r_araddr <= {miss_addr[ADDR_W-1:c_offset_width], {c_offset_width{1'b0}}};
              r_arlen  <= c_arlen_line;
              r_arsize <= c_size_8b;
            end else begin
              r_araddr <= {miss_addr[ADDR_W-1:2], 2'b00};
              r_arlen  <= 8'd0;
              r_arsize <= c_size_4b;
            end
          end
        end
        S_R: begin
          if (w_beat_acc) begin
            r_line[AXI_DATA_W*int'(r_beat) +: AXI_DATA_W] <= rdata;
            if (!r_cache) begin
              r_inst <= r_addr2 ? rdata[63:32] : rdata[31:0];
            end
            r_beat <= r_beat + 1'b1;
            r_err  <= w_err_next;
          end
        end
        S_DONE: begin
          r_err <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign refresh       = r_refresh;
  assign cacheline_new = r_line;
  assign refill_way    = r_way;
  assign refill_index  = r_index;
  assign uncached_inst = r_inst;
  assign miss_done     = r_miss_done;
  assign bus_err       = r_bus_err;
  assign arvalid       = r_arvalid;
  assign araddr        = r_araddr;
  assign arlen         = r_arlen;
  assign arsize        = r_arsize;
  assign arburst       = r_arburst;
  assign arid          = AXI_ID;
  assign rready        = r_rready;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_2022040010_icache_refill.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_2022040010_icache_refill
// Description : Self-checking bench for the icache refill engine. A scripted
//               AXI slave serves each miss; a directed table plus random
//               transactions are compared against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_2022040010_icache_refill;

  logic         clk = 1'b0;
  logic         rst;
  logic         miss_req;
  logic [63:0]  miss_addr;
  logic         cache;
  logic         lru_in;
  logic         refresh;
  logic [127:0] cacheline_new;
  logic         refill_way;
  logic [5:0]   refill_index;
  logic [31:0]  uncached_inst;
  logic         miss_done;
  logic         bus_err;
  logic         arvalid;
  logic         arready;
  logic [63:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic [3:0]   arid;
  logic         rvalid;
  logic         rready;
  logic [63:0]  rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic [3:0]   rid;

  always #5 clk = ~clk;

  ysyx_2022040010_icache_refill dut (
    .clk           (clk),
    .rst           (rst),
    .miss_req      (miss_req),
    .miss_addr     (miss_addr),
    .cache         (cache),
    .lru_in        (lru_in),
    .refresh       (refresh),
    .cacheline_new (cacheline_new),
    .refill_way    (refill_way),
    .refill_index  (refill_index),
    .uncached_inst (uncached_inst),
    .miss_done     (miss_done),
    .bus_err       (bus_err),
    .arvalid       (arvalid),
    .arready       (arready),
    .araddr        (araddr),
    .arlen         (arlen),
    .arsize        (arsize),
    .arburst       (arburst),
    .arid          (arid),
    .rvalid        (rvalid),
    .rready        (rready),
    .rdata         (rdata),
    .rresp         (rresp),
    .rlast         (rlast),
    .rid           (rid)
  );

  typedef struct {
    logic [63:0] addr;
    logic        cch;
    logic        lru;
    int          ar_wait;   // cycles arready stays low once arvalid is seen
    int          gap;       // idle rvalid cycles between beats
    int          nbeats;    // beats sent; rlast on the final one
    logic [1:0]  r0;
    logic [1:0]  r1;
    logic [63:0] d0;
    logic [63:0] d1;
    int          exp_ref_cyc;  // -1: no refresh expected
    int          exp_done_cyc;
    logic        exp_err;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // Reference state: what the line register and instruction should hold.
  logic [63:0] m_line [2];
  logic [31:0] m_inst;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected timing/error from the protocol rules: AR starts at cycle 1,
  // R starts the cycle after arready, beats are spaced 1+gap apart, and a
  // clean cached refill spends one extra cycle writing the arrays.
  function automatic vec_t fill_exp(input vec_t v);
    vec_t o;
    int   last;
    logic err;
    o    = v;
    last = 2 + v.ar_wait + (v.nbeats - 1) * (1 + v.gap);
    err  = (v.nbeats != (v.cch ? 2 : 1)) || (v.r0 != 2'b00) ||
           (v.nbeats > 1 && v.r1 != 2'b00);
    o.exp_err      = err;
    o.exp_ref_cyc  = (v.cch && !err) ? last + 1 : -1;
    o.exp_done_cyc = last + 1 + ((v.cch && !err) ? 1 : 0);
    return o;
  endfunction

  task automatic run_txn(input vec_t v);
    logic [63:0] d  [2];
    logic [1:0]  rs [2];
    logic [63:0] exp_addr;
    logic [63:0] o_araddr;
    logic [7:0]  o_arlen;
    logic [2:0]  o_arsize;
    logic [1:0]  o_arburst;
    logic [3:0]  o_arid;
    logic        o_stable;
    logic        done;
    logic        o_err;
    logic [127:0] o_line;
    logic [5:0]  o_idx;
    logic        o_way;
    int          ref_cnt, ref_cyc, done_cyc, ar_seen, sent, gap_left, cyc;
    d[0] = v.d0; d[1] = v.d1; rs[0] = v.r0; rs[1] = v.r1;
    o_stable = 1'b1; done = 1'b0; o_err = 1'b0; o_line = '0; o_idx = '0; o_way = 1'b0;
    o_araddr = '0; o_arlen = '0; o_arsize = '0; o_arburst = '0; o_arid = '0;
    ref_cnt = 0; ref_cyc = -1; done_cyc = -1; ar_seen = 0; sent = 0; gap_left = 0; cyc = 0;

    // Model: every accepted beat lands in the line; uncached beats also
    // update the returned instruction.
    for (int i = 0; i < v.nbeats; i++) begin
      m_line[i % 2] = d[i];
      if (!v.cch) m_inst = v.addr[2] ? d[i][63:32] : d[i][31:0];
    end

    @(posedge clk); #1;
    miss_req = 1'b1; miss_addr = v.addr; cache = v.cch; lru_in = v.lru;
    while (!done && cyc < 80) begin
      @(posedge clk); #1;
      cyc++;
      arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rdata = '0;
      if (arvalid) begin
        if (ar_seen == 0) begin
          o_araddr = araddr; o_arlen = arlen; o_arsize = arsize;
          o_arburst = arburst; o_arid = arid;
        end else if (araddr !== o_araddr) begin
          o_stable = 1'b0;
        end
        arready = (ar_seen >= v.ar_wait);
        ar_seen++;
      end
      if (rready && sent < v.nbeats) begin
        if (gap_left > 0) begin
          gap_left--;
        end else begin
          rvalid = 1'b1; rdata = d[sent]; rresp = rs[sent];
          rlast = (sent == v.nbeats - 1);
          sent++;
          gap_left = v.gap;
        end
      end
      if (refresh) begin
        ref_cnt++; ref_cyc = cyc;
        o_line = cacheline_new; o_idx = refill_index; o_way = refill_way;
      end
      if (miss_done) begin
        done_cyc = cyc; o_err = bus_err; miss_req = 1'b0; done = 1'b1;
      end
    end
    arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
    if (!done) begin
      total++; bad++;
      $display("FAIL timeout: got no miss_done expected miss_done within 80 cycles");
      miss_req = 1'b0;
    end

    exp_addr = v.cch ? {v.addr[63:4], 4'b0} : {v.addr[63:2], 2'b0};
    chk("araddr",  o_araddr, exp_addr);
    chk("arlen",   o_arlen,  v.cch ? 8'd1 : 8'd0);
    chk("arsize",  o_arsize, v.cch ? 3'd3 : 3'd2);
    chk("arburst", o_arburst, 2'b01);
    chk("arid",    o_arid,   4'd0);
    chk("araddr_stable", o_stable, 1'b1);
    chk("refresh_count", ref_cnt, (v.exp_ref_cyc >= 0) ? 1 : 0);
    if (v.exp_ref_cyc >= 0) begin
      chk("refresh_cycle", ref_cyc, v.exp_ref_cyc);
      chk("refresh_line",  o_line, {m_line[1], m_line[0]});
      chk("refresh_index", o_idx, v.addr[9:4]);
      chk("refresh_way",   o_way, v.lru);
    end
    chk("done_cycle", done_cyc, v.exp_done_cyc);
    chk("bus_err",    o_err, v.exp_err);
    chk("line_hold",  cacheline_new, {m_line[1], m_line[0]});
    chk("inst_hold",  uncached_inst, m_inst);
    chk("index_hold", refill_index, v.addr[9:4]);
    chk("way_hold",   refill_way, v.lru);
  endtask

  vec_t tbl [8];

  initial begin
    vec_t v;
    int   n;
    rst = 1'b0; miss_req = 1'b0; miss_addr = '0; cache = 1'b0; lru_in = 1'b0;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rid = 4'd0;
    m_line[0] = '0; m_line[1] = '0; m_inst = '0;

    //            addr                   c  w  arw gap nb r0     r1     d0                     d1                     ref done err
    tbl[0] = '{64'h0000_0000_8000_0134, 1, 1, 0, 0, 2, 2'b00, 2'b00, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 4, 5, 0};
    tbl[1] = '{64'h0000_0000_1000_0004, 0, 0, 0, 0, 1, 2'b00, 2'b00, 64'hAABB_CCDD_1122_3344, 64'h0,                  -1, 3, 0};
    tbl[2] = '{64'h0000_0000_8000_2a48, 1, 0, 3, 2, 2, 2'b00, 2'b00, 64'h0123_4567_89ab_cdef, 64'hfedc_ba98_7654_3210, 9, 10, 0};
    tbl[3] = '{64'h0000_0000_8000_0370, 1, 1, 0, 0, 2, 2'b00, 2'b10, 64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444, -1, 4, 1};
    tbl[4] = '{64'h0000_0000_8000_03f0, 1, 0, 0, 0, 2, 2'b00, 2'b00, 64'h5555_5555_5555_5555, 64'h6666_6666_6666_6666, 4, 5, 0};
    tbl[5] = '{64'h0000_0000_8000_0500, 1, 1, 0, 0, 1, 2'b00, 2'b00, 64'h7777_7777_7777_7777, 64'h0,                  -1, 3, 1};
    tbl[6] = '{64'h0000_0000_3000_0008, 0, 1, 1, 0, 1, 2'b00, 2'b00, 64'hDEAD_BEEF_CAFE_F00D, 64'h0,                  -1, 4, 0};
    tbl[7] = '{64'h0000_0000_3000_0014, 0, 0, 0, 0, 1, 2'b11, 2'b00, 64'h9999_8888_7777_6666, 64'h0,                  -1, 3, 1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_arvalid", arvalid, 1'b0);
    chk("rst_rready",  rready, 1'b0);
    chk("rst_refresh", refresh, 1'b0);
    chk("rst_miss_done", miss_done, 1'b0);
    chk("rst_bus_err", bus_err, 1'b0);
    chk("rst_araddr",  araddr, 64'h0);
    chk("rst_arlen",   arlen, 8'h0);
    chk("rst_arsize",  arsize, 3'h0);
    chk("rst_arburst", arburst, 2'h0);
    chk("rst_line",    cacheline_new, 128'h0);
    chk("rst_way",     refill_way, 1'b0);
    chk("rst_index",   refill_index, 6'h0);
    chk("rst_inst",    uncached_inst, 32'h0);
    rst = 1'b1;

    // Directed table
    for (int i = 0; i < 8; i++) run_txn(tbl[i]);

    // Reset in the middle of the R phase
    @(posedge clk); #1;
    miss_req = 1'b1; miss_addr = 64'h8000_0780; cache = 1'b1; lru_in = 1'b1; arready = 1'b1;
    n = 0;
    while (!rready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    arready = 1'b0;
    chk("midR_reached", rready, 1'b1);
    rst = 1'b0;
    miss_req = 1'b0;
    #1;
    chk("midR_rready",    rready, 1'b0);
    chk("midR_arvalid",   arvalid, 1'b0);
    chk("midR_refresh",   refresh, 1'b0);
    chk("midR_miss_done", miss_done, 1'b0);
    chk("midR_state",     dut.r_state, 3'd0);
    m_line[0] = '0; m_line[1] = '0; m_inst = '0;
    @(posedge clk); #2;
    rst = 1'b1;
    v = '{64'h0000_0000_8000_0a10, 1, 0, 0, 0, 2, 2'b00, 2'b00, 64'hABCD_0000_1234_5678, 64'h0F0F_F0F0_0F0F_F0F0, 4, 5, 0};
    run_txn(v);

    // Random transactions against the model
    for (int i = 0; i < 24; i++) begin
      v.addr    = {$urandom, $urandom};
      v.cch     = 1'($urandom_range(0, 1));
      v.lru     = 1'($urandom_range(0, 1));
      v.ar_wait = $urandom_range(0, 3);
      v.gap     = $urandom_range(0, 2);
      if (v.cch) v.nbeats = ($urandom_range(0, 7) == 0) ? 1 : 2;
      else       v.nbeats = ($urandom_range(0, 7) == 0) ? 2 : 1;
      v.r0 = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      v.r1 = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      v.d0 = {$urandom, $urandom};
      v.d1 = {$urandom, $urandom};
      run_txn(fill_exp(v));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
